// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock: BCD 24-hour time-of-day counter with NUM_ALARMS independent
// alarm channels (arm/disarm, snooze, auto-stop). All outputs are registered.
//
//   state      | meaning
//   ST_IDLE    | channel disarmed, never rings
//   ST_ARMED   | waits for time to roll onto stored alarm H:M:00
//   ST_RINGING | requesting buzzer; auto-stop minute timer running
//   ST_SNOOZED | waits for time to roll onto snooze target H:M:00
module multi_alarm_clock #(
    parameter int  NUM_ALARMS   = 4,
    parameter int  TICK_DIV     = 10,
    parameter int  SNOOZE_MIN   = 5,
    parameter int  RING_MAX_MIN = 2,
    localparam int SEL_W        = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       H_in1,
    input  logic [3:0]       H_in0,
    input  logic [3:0]       M_in1,
    input  logic [3:0]       M_in0,
    input  logic             LD_time,
    input  logic             LD_alarm,
    input  logic [SEL_W-1:0] AL_SEL,
    input  logic             AL_ON,
    input  logic             STOP_al,
    input  logic             SNOOZE,
    output logic             Alarm,
    output logic [SEL_W-1:0] Alarm_id,
    output logic             load_err,
    output logic [1:0]       H_out1,
    output logic [3:0]       H_out0,
    output logic [3:0]       M_out1,
    output logic [3:0]       M_out0,
    output logic [3:0]       S_out1,
    output logic [3:0]       S_out0
);
    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_RINGING, ST_SNOOZED} ch_state_e;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [5:0] RING_CNT = 6'(RING_MAX_MIN);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    h1_q, h1_d, inc_h1;
    logic [3:0]    h0_q, h0_d, inc_h0, m1_q, m1_d, inc_m1, m0_q, m0_d, inc_m0;
    logic [3:0]    s1_q, s1_d, inc_s1, s0_q, s0_d, inc_s0;

    ch_state_e     st_q    [NUM_ALARMS];
    ch_state_e     st_d    [NUM_ALARMS];
    logic [13:0]   alarm_q [NUM_ALARMS];
    logic [13:0]   alarm_d [NUM_ALARMS];
    logic [13:0]   snz_q   [NUM_ALARMS];
    logic [13:0]   snz_d   [NUM_ALARMS];
    logic [5:0]    ring_q  [NUM_ALARMS];
    logic [5:0]    ring_d  [NUM_ALARMS];

    logic             buzz_q, buzz_d, err_q, err_d;
    logic [SEL_W-1:0] buzz_id_q, buzz_id_d;

    logic        in_valid, sel_ok, ld_time_ok, ld_alarm_ok, tick, min_roll;
    logic [13:0] hm_in, next_hm, snooze_hm;

    // Current H:M plus the snooze length, wrapping through midnight.
    function automatic logic [13:0] add_snooze(input logic [13:0] hm);
        int h;
        int m;
        h = int'(hm[13:12]) * 10 + int'(hm[11:8]);
        m = int'(hm[7:4]) * 10 + int'(hm[3:0]) + SNOOZE_MIN;
        if (m >= 60) begin
            m = m - 60;
            h = h + 1;
        end
        if (h >= 24) h = h - 24;
        return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    assign hm_in      = {H_in1, H_in0, M_in1, M_in0};
    assign in_valid   = (H_in0 <= 4'd9) && (M_in0 <= 4'd9) && (M_in1 <= 4'd5) &&
                        ((H_in1 < 2'd2) || ((H_in1 == 2'd2) && (H_in0 <= 4'd3)));
    assign sel_ok     = int'(AL_SEL) < NUM_ALARMS;
    // LD_time has priority: a simultaneous alarm load is silently dropped.
    assign ld_time_ok  = LD_time && in_valid;
    assign ld_alarm_ok = LD_alarm && !LD_time && in_valid && sel_ok;
    assign err_d       = (LD_time && !in_valid) || (LD_alarm && !LD_time && !(in_valid && sel_ok));

    assign tick      = (presc_q == PW'(TICK_DIV - 1)) && !ld_time_ok;
    // Matches only happen when a tick rolls seconds from 59 to 00, so LD_time can never ring.
    assign min_roll  = tick && (s0_q == 4'd9) && (s1_q == 4'd5);
    assign next_hm   = {inc_h1, inc_h0, inc_m1, inc_m0};
    assign snooze_hm = add_snooze({h1_q, h0_q, m1_q, m0_q});

    // Time plus one second, BCD with cascaded carries and 23:59:59 wrap.
    always_comb begin
        inc_s0 = s0_q + 4'd1;
        inc_s1 = s1_q;
        inc_m0 = m0_q;
        inc_m1 = m1_q;
        inc_h0 = h0_q;
        inc_h1 = h1_q;
        if (s0_q == 4'd9) begin
            inc_s0 = 4'd0;
            if (s1_q == 4'd5) begin
                inc_s1 = 4'd0;
                if (m0_q == 4'd9) begin
                    inc_m0 = 4'd0;
                    if (m1_q == 4'd5) begin
                        inc_m1 = 4'd0;
                        if ((h1_q == 2'd2) && (h0_q == 4'd3)) begin
                            inc_h1 = 2'd0;
                            inc_h0 = 4'd0;
                        end else if (h0_q == 4'd9) begin
                            inc_h0 = 4'd0;
                            inc_h1 = h1_q + 2'd1;
                        end else begin
                            inc_h0 = h0_q + 4'd1;
                        end
                    end else begin
                        inc_m1 = m1_q + 4'd1;
                    end
                end else begin
                    inc_m0 = m0_q + 4'd1;
                end
            end else begin
                inc_s1 = s1_q + 4'd1;
            end
        end
    end

    // Next prescaler and time: a valid LD_time reloads, otherwise advance on tick.
    always_comb begin
        presc_d = (presc_q == PW'(TICK_DIV - 1)) ? '0 : presc_q + PW'(1);
        {h1_d, h0_d, m1_d, m0_d, s1_d, s0_d} = {h1_q, h0_q, m1_q, m0_q, s1_q, s0_q};
        if (ld_time_ok) begin
            presc_d = '0;
            {h1_d, h0_d, m1_d, m0_d} = hm_in;
            {s1_d, s0_d} = 8'h00;
        end else if (tick) begin
            {h1_d, h0_d, m1_d, m0_d, s1_d, s0_d} = {inc_h1, inc_h0, inc_m1, inc_m0, inc_s1, inc_s0};
        end
    end

    // Time-of-day and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q   <= '0;
            {h1_q, h0_q, m1_q, m0_q, s1_q, s0_q} <= '0;
            buzz_q    <= 1'b0;
            buzz_id_q <= '0;
            err_q     <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            {h1_q, h0_q, m1_q, m0_q, s1_q, s0_q} <= {h1_d, h0_d, m1_d, m0_d, s1_d, s0_d};
            buzz_q    <= buzz_d;
            buzz_id_q <= buzz_id_d;
            err_q     <= err_d;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                st_q[i]    <= ST_IDLE;
                alarm_q[i] <= '0;
                snz_q[i]   <= '0;
                ring_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                st_q[i]    <= st_d[i];
                alarm_q[i] <= alarm_d[i];
                snz_q[i]   <= snz_d[i];
                ring_q[i]  <= ring_d[i];
            end
        end
    end

    // Per-channel next state; buzzer outputs are derived from next state so they
    // change on the same edge as the time that caused them.
    always_comb begin
        buzz_d    = 1'b0;
        buzz_id_d = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            st_d[i]    = st_q[i];
            alarm_d[i] = alarm_q[i];
            snz_d[i]   = snz_q[i];
            ring_d[i]  = ring_q[i];
            if (ld_alarm_ok && (int'(AL_SEL) == i)) begin
                alarm_d[i] = hm_in;
                st_d[i]    = AL_ON ? ST_ARMED : ST_IDLE;
            end else begin
                case (st_q[i])
                    ST_ARMED: begin
                        if (min_roll && (next_hm == alarm_q[i])) begin
                            st_d[i]   = ST_RINGING;
                            ring_d[i] = RING_CNT;
                        end
                    end
                    ST_RINGING: begin
                        if (STOP_al) begin
                            st_d[i] = ST_ARMED;
                        end else if (SNOOZE) begin
                            st_d[i]  = ST_SNOOZED;
                            snz_d[i] = snooze_hm;
                        end else if (min_roll) begin
                            if (ring_q[i] == 6'd1) st_d[i] = ST_ARMED;
                            else ring_d[i] = ring_q[i] - 6'd1;
                        end
                    end
                    ST_SNOOZED: begin
                        if (STOP_al) begin
                            st_d[i] = ST_ARMED;
                        end else if (min_roll && (next_hm == snz_q[i])) begin
                            st_d[i]   = ST_RINGING;
                            ring_d[i] = RING_CNT;
                        end
                    end
                    default: st_d[i] = st_q[i];
                endcase
            end
        end
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (st_d[i] == ST_RINGING) begin
                buzz_d    = 1'b1;
                buzz_id_d = SEL_W'(i);
            end
        end
    end

    assign Alarm    = buzz_q;
    assign Alarm_id = buzz_id_q;
    assign load_err = err_q;
    assign H_out1   = h1_q;
    assign H_out0   = h0_q;
    assign M_out1   = m1_q;
    assign M_out0   = m0_q;
    assign S_out1   = s1_q;
    assign S_out0   = s0_q;
endmodule

// File: tb/tb_multi_alarm_clock.sv
// Bench for multi_alarm_clock: expected rings are queued when alarms are set up
// and popped when Alarm rises; other behaviour is checked inline per scenario.
`timescale 1ns/1ps
module tb_multi_alarm_clock;
    // Three channels so that an out-of-range select (3) fits in the 2-bit AL_SEL.
    localparam int NA = 3;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    H_in1;
    logic [3:0]    H_in0, M_in1, M_in0;
    logic          LD_time, LD_alarm, AL_ON, STOP_al, SNOOZE;
    logic [SW-1:0] AL_SEL;
    logic          Alarm, load_err;
    logic [SW-1:0] Alarm_id;
    logic [1:0]    H_out1;
    logic [3:0]    H_out0, M_out1, M_out0, S_out1, S_out0;

    multi_alarm_clock #(.NUM_ALARMS(NA), .TICK_DIV(2), .SNOOZE_MIN(5), .RING_MAX_MIN(2)) dut (
        .clk(clk), .reset(reset),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm), .AL_SEL(AL_SEL), .AL_ON(AL_ON),
        .STOP_al(STOP_al), .SNOOZE(SNOOZE),
        .Alarm(Alarm), .Alarm_id(Alarm_id), .load_err(load_err),
        .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
        .S_out1(S_out1), .S_out0(S_out0)
    );

    always #5 clk = ~clk;

    typedef struct { int h; int m; int id; } ring_t;
    ring_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic integer cur_h(); return H_out1 * 10 + H_out0; endfunction
    function automatic integer cur_m(); return M_out1 * 10 + M_out0; endfunction
    function automatic integer cur_s(); return S_out1 * 10 + S_out0; endfunction

    task automatic drive_hm(input int h, input int m);
        H_in1 = 2'(h / 10); H_in0 = 4'(h % 10); M_in1 = 4'(m / 10); M_in0 = 4'(m % 10);
    endtask

    task automatic load_time(input int h, input int m);
        @(negedge clk); drive_hm(h, m); LD_time = 1'b1;
        @(negedge clk); LD_time = 1'b0;
    endtask

    task automatic load_alarm(input int sel, input int h, input int m, input bit on);
        @(negedge clk); drive_hm(h, m); AL_SEL = SW'(sel); AL_ON = on; LD_alarm = 1'b1;
        @(negedge clk); LD_alarm = 1'b0;
    endtask

    // Called on a negedge; the button is sampled at the following posedge.
    task automatic press(input bit stop, input bit snz);
        STOP_al = stop; SNOOZE = snz;
        @(negedge clk); STOP_al = 1'b0; SNOOZE = 1'b0;
    endtask

    task automatic wait_ring(input int budget, output bit seen,
                             output integer h, output integer m, output integer s, output integer id);
        seen = 1'b0; h = -1; m = -1; s = -1; id = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (Alarm === 1'b1) begin
                seen = 1'b1; h = cur_h(); m = cur_m(); s = cur_s(); id = Alarm_id;
                break;
            end
        end
    endtask

    task automatic wait_quiet(input int cycles, output bit rang);
        rang = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (Alarm !== 1'b0) rang = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        LD_time = 0; LD_alarm = 0; AL_ON = 0; STOP_al = 0; SNOOZE = 0; AL_SEL = '0;
        drive_hm(0, 0);
        repeat (3) @(negedge clk);
        n_tests++;
        if (Alarm !== 1'b0 || load_err !== 1'b0 || Alarm_id !== '0) begin
            n_fail++; $display("FAIL reset_outputs: Alarm=%b load_err=%b id=%0d, want 0 0 0", Alarm, load_err, Alarm_id);
        end
        n_tests++;
        if (cur_h() !== 0 || cur_m() !== 0 || cur_s() !== 0) begin
            n_fail++; $display("FAIL reset_time: got %0d:%0d:%0d, want 0:0:0", cur_h(), cur_m(), cur_s());
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        ring_t e; bit seen; integer h, m, s, id;
        load_time(10, 19);
        load_alarm(0, 10, 20, 1);
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back('{10, 20, 0});
            wait_ring(300, seen, h, m, s, id);
            e = exp_q.pop_front();
            n_tests++;
            if (!seen || h !== e.h || m !== e.m || s !== 0 || id !== e.id) begin
                n_fail++; $display("FAIL basic_ring%0d: seen=%0d %0d:%0d:%0d id=%0d, want %0d:%0d:0 id=%0d", k, seen, h, m, s, id, e.h, e.m, e.id);
            end
            press(1, 0);
            n_tests++;
            if (Alarm !== 1'b0) begin n_fail++; $display("FAIL basic_stop%0d: Alarm=%b, want 0", k, Alarm); end
            if (k == 0) load_time(10, 19);
        end
    endtask

    task automatic test_snooze();
        ring_t e; bit seen; integer h, m, s, id;
        load_alarm(1, 23, 58, 1);
        load_time(23, 57);
        exp_q.push_back('{23, 58, 1});
        wait_ring(300, seen, h, m, s, id);
        e = exp_q.pop_front();
        n_tests++;
        if (!seen || h !== e.h || m !== e.m || s !== 0 || id !== e.id) begin
            n_fail++; $display("FAIL snooze_first: seen=%0d %0d:%0d:%0d id=%0d, want %0d:%0d:0 id=%0d", seen, h, m, s, id, e.h, e.m, e.id);
        end
        press(0, 1);
        n_tests++;
        if (Alarm !== 1'b0) begin n_fail++; $display("FAIL snooze_quiet: Alarm=%b, want 0", Alarm); end
        exp_q.push_back('{0, 3, 1});
        wait_ring(800, seen, h, m, s, id);
        e = exp_q.pop_front();
        n_tests++;
        if (!seen || h !== e.h || m !== e.m || s !== 0 || id !== e.id) begin
            n_fail++; $display("FAIL snooze_rering: seen=%0d %0d:%0d:%0d id=%0d, want %0d:%0d:0 id=%0d", seen, h, m, s, id, e.h, e.m, e.id);
        end
        press(1, 0);
        n_tests++;
        if (Alarm !== 1'b0) begin n_fail++; $display("FAIL snooze_stop: Alarm=%b, want 0", Alarm); end
    endtask

    task automatic test_multi();
        ring_t e; bit seen; integer h, m, s, id;
        load_alarm(0, 6, 30, 1);
        load_alarm(2, 6, 30, 1);
        for (int k = 0; k < 2; k++) begin
            load_time(6, 29);
            exp_q.push_back('{6, 30, 0});
            wait_ring(300, seen, h, m, s, id);
            e = exp_q.pop_front();
            n_tests++;
            if (!seen || h !== e.h || m !== e.m || s !== 0 || id !== e.id) begin
                n_fail++; $display("FAIL multi_ring%0d: seen=%0d %0d:%0d:%0d id=%0d, want %0d:%0d:0 id=%0d", k, seen, h, m, s, id, e.h, e.m, e.id);
            end
            if (k == 1) begin
                // Disarming ch0 mid-ring must leave ch2 as the ringing channel.
                load_alarm(0, 6, 30, 0);
                n_tests++;
                if (Alarm !== 1'b1 || Alarm_id !== 2'd2) begin
                    n_fail++; $display("FAIL multi_ch2: Alarm=%b id=%0d, want 1 id=2", Alarm, Alarm_id);
                end
            end
            press(1, 0);
            n_tests++;
            if (Alarm !== 1'b0) begin n_fail++; $display("FAIL multi_stop%0d: Alarm=%b id=%0d, want 0", k, Alarm, Alarm_id); end
        end
    endtask

    task automatic test_autostop();
        ring_t e; bit seen, fell; integer h, m, s, id;
        for (int k = 0; k < 2; k++) begin
            load_time(6, 29);
            exp_q.push_back('{6, 30, 2});
            wait_ring(300, seen, h, m, s, id);
            e = exp_q.pop_front();
            n_tests++;
            if (!seen || h !== e.h || m !== e.m || s !== 0 || id !== e.id) begin
                n_fail++; $display("FAIL auto_ring%0d: seen=%0d %0d:%0d:%0d id=%0d, want %0d:%0d:0 id=%0d", k, seen, h, m, s, id, e.h, e.m, e.id);
            end
            if (k == 1) begin
                press(1, 0);
                n_tests++;
                if (Alarm !== 1'b0) begin n_fail++; $display("FAIL auto_stop: Alarm=%b, want 0", Alarm); end
            end else begin
                fell = 1'b0;
                for (int i = 0; i < 400; i++) begin
                    @(negedge clk);
                    if (Alarm === 1'b0) begin fell = 1'b1; break; end
                end
                n_tests++;
                if (!fell || cur_h() !== 6 || cur_m() !== 32 || cur_s() !== 0) begin
                    n_fail++; $display("FAIL auto_timeout: fell=%0d at %0d:%0d:%0d, want fall at 6:32:0", fell, cur_h(), cur_m(), cur_s());
                end
            end
        end
    endtask

    task automatic test_load_err();
        bit rang;
        load_time(12, 0);
        n_tests++;
        if (load_err !== 1'b0) begin n_fail++; $display("FAIL err_valid_time: load_err=%b, want 0", load_err); end
        load_time(24, 0);
        n_tests++;
        if (load_err !== 1'b1) begin n_fail++; $display("FAIL err_time_24: load_err=%b, want 1", load_err); end
        @(negedge clk);
        n_tests++;
        if (load_err !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle: load_err=%b, want 0", load_err); end
        load_alarm(0, 12, 60, 1);
        n_tests++;
        if (load_err !== 1'b1) begin n_fail++; $display("FAIL err_alarm_m60: load_err=%b, want 1", load_err); end
        load_alarm(3, 12, 1, 1);
        n_tests++;
        if (load_err !== 1'b1) begin n_fail++; $display("FAIL err_sel_range: load_err=%b, want 1", load_err); end
        n_tests++;
        if (cur_h() !== 12 || cur_m() !== 0) begin
            n_fail++; $display("FAIL err_time_kept: got %0d:%0d, want 12:0", cur_h(), cur_m());
        end
        wait_quiet(150, rang);
        n_tests++;
        if (rang) begin n_fail++; $display("FAIL err_no_ring: Alarm rang after rejected loads, want quiet"); end
    endtask

    task automatic test_both_loads();
        bit rang;
        @(negedge clk);
        drive_hm(8, 0); AL_SEL = 2'd0; AL_ON = 1'b1; LD_time = 1'b1; LD_alarm = 1'b1;
        @(negedge clk);
        LD_time = 1'b0; LD_alarm = 1'b0;
        n_tests++;
        if (load_err !== 1'b0 || cur_h() !== 8 || cur_m() !== 0 || cur_s() !== 0) begin
            n_fail++; $display("FAIL both_time: load_err=%b time %0d:%0d:%0d, want 0 8:0:0", load_err, cur_h(), cur_m(), cur_s());
        end
        // ch0 must still be disarmed, so rolling through 08:00:00 stays quiet.
        load_time(7, 59);
        wait_quiet(160, rang);
        n_tests++;
        if (rang) begin n_fail++; $display("FAIL both_alarm_dropped: ch0 rang at 08:00, want quiet"); end
        load_time(6, 30);
        wait_quiet(20, rang);
        n_tests++;
        if (rang) begin n_fail++; $display("FAIL ldtime_no_ring: rang after LD_time onto 06:30, want quiet"); end
    endtask

    task automatic test_reset_ring();
        ring_t e; bit seen; integer h, m, s, id;
        load_time(6, 29);
        exp_q.push_back('{6, 30, 2});
        wait_ring(300, seen, h, m, s, id);
        e = exp_q.pop_front();
        n_tests++;
        if (!seen || h !== e.h || m !== e.m || s !== 0 || id !== e.id) begin
            n_fail++; $display("FAIL rst_ring: seen=%0d %0d:%0d:%0d id=%0d, want %0d:%0d:0 id=%0d", seen, h, m, s, id, e.h, e.m, e.id);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (Alarm !== 1'b0 || Alarm_id !== '0 || load_err !== 1'b0) begin
            n_fail++; $display("FAIL rst_async_out: Alarm=%b id=%0d err=%b, want 0 0 0", Alarm, Alarm_id, load_err);
        end
        n_tests++;
        if (cur_h() !== 0 || cur_m() !== 0 || cur_s() !== 0) begin
            n_fail++; $display("FAIL rst_async_time: %0d:%0d:%0d, want 0:0:0", cur_h(), cur_m(), cur_s());
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_snooze();
        test_multi();
        test_autostop();
        test_load_err();
        test_both_loads();
        test_reset_ring();
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d pending, want 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
